// File: rtl/lcd_bus_model.sv
// rtl/lcd_bus_model.sv - HD44780-style 8-bit LCD bus receiver with 2x16 character buffer
// Transfers execute on the registered falling edge of en; a clear sweeps the buffer with spaces.
module lcd_bus_model #(
   parameter int CLR_CYCLES = 32,
   parameter int CMD_CYCLES = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        rs_i,
   input  logic        wr_i,
   input  logic [7:0]  lcd_data_i,
   input  logic [4:0]  rd_addr_i,
   output logic [7:0]  rd_char_o,
   output logic        busy_o,
   output logic        display_on_o,
   output logic [6:0]  cursor_addr_o,
   output logic [15:0] write_count_o,
   output logic [7:0]  clear_count_o,
   output logic        last_wr_o,
   output logic        err_busy_o
);

   typedef enum logic [1:0] {ST_FILL, ST_BUSY, ST_IDLE} state_t;

   localparam logic [15:0] CLR_REM = 16'(CLR_CYCLES - 32);
   localparam logic [15:0] CMD_LEN = 16'(CMD_CYCLES);

   state_t      state_q, state_d;
   logic [4:0]  fill_idx_q, fill_idx_d;
   logic [15:0] cnt_q, cnt_d;

   logic        s_en_q, s_rs_q, s_wr_q, prev_en_q;
   logic [7:0]  s_data_q;
   logic        h_rs_q, h_wr_q;
   logic [7:0]  h_data_q;

   logic [7:0]  buf_q [32];
   logic [7:0]  rd_char_q;
   logic        display_on_q, inc_q, last_wr_q, err_busy_q;
   logic [6:0]  cursor_q, cur_step;
   logic [15:0] write_count_q;
   logic [7:0]  clear_count_q;

   logic        busy, strobe, accept, is_clear, data_we, fill_we;
   logic [4:0]  data_idx;

   assign busy     = (state_q != ST_IDLE);
   assign strobe   = prev_en_q & ~s_en_q;
   assign accept   = strobe & ~busy;
   assign is_clear = ~h_rs_q & (h_data_q == 8'h01);
   // Only 0x00-0x0F and 0x40-0x4F are backed by the buffer; bit 6 selects the line.
   assign data_we  = accept & h_rs_q & ~rst_i &
                     ((cursor_q[6:4] == 3'b000) | (cursor_q[6:4] == 3'b100));
   assign data_idx = {cursor_q[6], cursor_q[3:0]};
   assign fill_we  = (state_q == ST_FILL) & ~rst_i;

   always_comb begin
      cur_step = cursor_q;
      if (inc_q) begin
         if (cursor_q == 7'h27)      cur_step = 7'h40;
         else if (cursor_q == 7'h67) cur_step = 7'h00;
         else                        cur_step = cursor_q + 7'd1;
      end else begin
         if (cursor_q == 7'h00)      cur_step = 7'h67;
         else if (cursor_q == 7'h40) cur_step = 7'h27;
         else                        cur_step = cursor_q - 7'd1;
      end
   end

   always_comb begin
      state_d    = state_q;
      fill_idx_d = fill_idx_q;
      cnt_d      = cnt_q;
      case (state_q)
         ST_FILL: begin
            fill_idx_d = fill_idx_q + 5'd1;
            if (fill_idx_q == 5'd31) begin
               fill_idx_d = 5'd0;
               if (CLR_REM == 16'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = CLR_REM;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q <= 16'd1) state_d = ST_IDLE;
            else                cnt_d   = cnt_q - 16'd1;
         end
         default: begin
            if (accept) begin
               if (is_clear) begin
                  state_d    = ST_FILL;
                  fill_idx_d = 5'd0;
               end else if (CMD_LEN != 16'd0) begin
                  state_d = ST_BUSY;
                  cnt_d   = CMD_LEN;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_FILL;
         fill_idx_q <= 5'd0;
         cnt_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         fill_idx_q <= fill_idx_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_we)      buf_q[fill_idx_q] <= 8'h20;
      else if (data_we) buf_q[data_idx]   <= h_data_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s_en_q        <= 1'b0;
         s_rs_q        <= 1'b0;
         s_wr_q        <= 1'b0;
         s_data_q      <= 8'h00;
         prev_en_q     <= 1'b0;
         h_rs_q        <= 1'b0;
         h_wr_q        <= 1'b0;
         h_data_q      <= 8'h00;
         rd_char_q     <= 8'h00;
         display_on_q  <= 1'b0;
         inc_q         <= 1'b1;
         cursor_q      <= 7'h00;
         write_count_q <= 16'h0000;
         clear_count_q <= 8'h00;
         last_wr_q     <= 1'b0;
         err_busy_q    <= 1'b0;
      end else begin
         s_en_q    <= en_i;
         s_rs_q    <= rs_i;
         s_wr_q    <= wr_i;
         s_data_q  <= lcd_data_i;
         prev_en_q <= s_en_q;
         rd_char_q <= buf_q[rd_addr_i];
         if (s_en_q) begin
            h_rs_q   <= s_rs_q;
            h_wr_q   <= s_wr_q;
            h_data_q <= s_data_q;
         end
         if (strobe) begin
            last_wr_q <= h_wr_q;
            if (busy) err_busy_q <= 1'b1;
         end
         if (accept) begin
            if (h_rs_q) begin
               if (write_count_q != 16'hFFFF) write_count_q <= write_count_q + 16'd1;
               cursor_q <= cur_step;
            end else if (h_data_q[7]) begin
               cursor_q <= h_data_q[6:0];
            end else if (h_data_q[6:4] == 3'b000) begin
               // Highest set bit picks the command; CGRAM, function set and shift are no-ops.
               if (h_data_q[3]) begin
                  display_on_q <= h_data_q[2];
               end else if (h_data_q[2]) begin
                  inc_q <= h_data_q[1];
               end else if (h_data_q[1]) begin
                  cursor_q <= 7'h00;
               end else if (h_data_q[0]) begin
                  cursor_q      <= 7'h00;
                  inc_q         <= 1'b1;
                  clear_count_q <= clear_count_q + 8'd1;
               end
            end
         end
      end
   end

   assign rd_char_o     = rd_char_q;
   assign busy_o        = busy;
   assign display_on_o  = display_on_q;
   assign cursor_addr_o = cursor_q;
   assign write_count_o = write_count_q;
   assign clear_count_o = clear_count_q;
   assign last_wr_o     = last_wr_q;
   assign err_busy_o    = err_busy_q;

endmodule
